// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the mult_seq shift-and-add multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // Bits needed for a down-counter that starts at w and ends at 1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/adder.sv
// LCELL-style ripple-carry adder: width_p-bit operands, width_p+1-bit sum
// with the carry-out kept as the top bit.
module adder #(
    parameter int width_p = 5
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p:0]   s_o
);

    logic carry_s;

    // Ripple the carry through one full-adder cell per bit.
    always_comb begin
        carry_s = 1'b0;
        s_o     = {(width_p + 1){1'b0}};
        for (int i = 0; i < width_p; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ carry_s;
            carry_s = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
        end
        s_o[width_p] = carry_s;
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-and-add unsigned multiplier built around one ripple-carry
// adder. Operands enter on a valid/ready handshake; the product leaves on a
// valid/yumi handshake.
// Optional build macro: MULT_SEQ_ZERO_SKIP_EN -- a zero operand at accept
// jumps straight to DONE with a zero product instead of iterating.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int width_p = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     a_i,
    input  logic [width_p-1:0]     b_i,
    output logic                   v_o,
    input  logic                   yumi_i,
    output logic [2*width_p-1:0]   prod_o
);

    localparam int cnt_w_lp = cnt_width(width_p);
    localparam logic [cnt_w_lp-1:0] cnt_init_lp = cnt_w_lp'(width_p);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);

    mult_state_e            state_r;
    mult_state_e            state_n_s;
    logic [width_p-1:0]     mcand_r;
    logic [2*width_p-1:0]   prod_r;
    logic [cnt_w_lp-1:0]    cnt_r;
    logic                   ready_r;
    logic                   v_r;
    logic [width_p:0]       sum_s;
    logic                   accept_s;
    logic                   zero_op_s;

    // Accumulator (upper half of prod_r) plus multiplicand; carry is kept.
    adder #(.width_p(width_p)) u_adder (
        .a_i (prod_r[2*width_p-1:width_p]),
        .b_i (mcand_r),
        .s_o (sum_s)
    );

    assign accept_s = v_i & (state_r == IDLE);

`ifdef MULT_SEQ_ZERO_SKIP_EN
    assign zero_op_s = (a_i == {width_p{1'b0}}) | (b_i == {width_p{1'b0}});
`else
    assign zero_op_s = 1'b0;
`endif

    assign ready_o = ready_r;
    assign v_o     = v_r;
    assign prod_o  = prod_r;

    // Next-state selection for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n_s = zero_op_s ? DONE : BUSY;
                end else begin
                    state_n_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == cnt_one_lp) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = BUSY;
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DONE;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            v_r     <= 1'b0;
        end else begin
            state_r <= state_n_s;
            ready_r <= (state_n_s == IDLE);
            v_r     <= (state_n_s == DONE);
        end
    end

    // Datapath: load operands, then one shift (with optional add) per BUSY cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mcand_r <= {width_p{1'b0}};
            prod_r  <= {(2*width_p){1'b0}};
            cnt_r   <= {cnt_w_lp{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mcand_r <= a_i;
                        cnt_r   <= cnt_init_lp;
                        if (zero_op_s) begin
                            prod_r <= {(2*width_p){1'b0}};
                        end else begin
                            prod_r <= {{width_p{1'b0}}, b_i};
                        end
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r - cnt_one_lp;
                    if (prod_r[0]) begin
                        prod_r <= {sum_s, prod_r[width_p-1:1]};
                    end else begin
                        prod_r <= {1'b0, prod_r[2*width_p-1:1]};
                    end
                end
                DONE: begin
                    prod_r <= prod_r;
                end
                default: begin
                    prod_r <= prod_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: a transaction-level model predicts the
// handshake and product every cycle; directed vectors carry literal products
// and latencies that pin the model.
`timescale 1ns/1ps
module tb_mult_seq;

    localparam int W = 5;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = W;
`endif

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           v_i    = 1'b0;
    logic           yumi_i = 1'b0;
    logic [W-1:0]   a_i    = '0;
    logic [W-1:0]   b_i    = '0;
    logic           ready_o;
    logic           v_o;
    logic [2*W-1:0] prod_o;

    mult_seq #(.width_p(W)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .v_o       (v_o),
        .yumi_i    (yumi_i),
        .prod_o    (prod_o)
    );

    always #5 clk = ~clk;

    // ---------------- transaction model ----------------
    int cyc = 0, acc_cyc = 0, lat = 0, exp_prod = 0;
    int cur_lit_prod = -1, cur_lit_lat = -1;
    int lit_prod = -1, lit_lat = -1;
    int n_acc = 0, n_cons = 0;
    bit pending = 1'b0;

    // driver bookkeeping
    int n_issued = 0, n_expected = 0, to_cnt = 0;
    bit end_chk = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (!pending && v_i) begin
                pending      <= 1'b1;
                acc_cyc      <= cyc + 1;
                exp_prod     <= int'(a_i) * int'(b_i);
                lat          <= (a_i == '0 || b_i == '0) ? ZLAT : W;
                cur_lit_prod <= lit_prod;
                cur_lit_lat  <= lit_lat;
                n_acc        <= n_acc + 1;
            end else if (pending && (cyc - acc_cyc >= lat) && yumi_i) begin
                pending <= 1'b0;
                n_cons  <= n_cons + 1;
            end
        end
    end

    function automatic bit model_vo();
        return pending && (cyc - acc_cyc >= lat);
    endfunction

    // ---------------- compare process ----------------
    int n_chk = 0, n_fail = 0;
    bit prev_vo = 1'b0;

    always @(negedge clk) begin
        bit             evo;
        logic [2*W-1:0] ep;
        evo = model_vo();
        ep  = exp_prod[2*W-1:0];
        n_chk++;
        if (ready_o !== !pending) begin
            n_fail++;
            $display("FAIL ready_o cyc=%0d got=%b want=%b", cyc, ready_o, !pending);
        end
        n_chk++;
        if (v_o !== evo) begin
            n_fail++;
            $display("FAIL v_o cyc=%0d got=%b want=%b", cyc, v_o, evo);
        end
        if (evo) begin
            n_chk++;
            if (prod_o !== ep) begin
                n_fail++;
                $display("FAIL prod_o cyc=%0d got=%0d want=%0d", cyc, prod_o, ep);
            end
        end
        if (!rst_n) begin
            n_chk++;
            if (prod_o !== '0) begin
                n_fail++;
                $display("FAIL reset_prod got=%0d want=0", prod_o);
            end
        end
        if (v_o && !prev_vo && pending && cur_lit_lat >= 0) begin
            n_chk++;
            if (cyc - acc_cyc != cur_lit_lat) begin
                n_fail++;
                $display("FAIL latency got=%0d want=%0d", cyc - acc_cyc, cur_lit_lat);
            end
            n_chk++;
            if (int'(prod_o) != cur_lit_prod) begin
                n_fail++;
                $display("FAIL literal_prod got=%0d want=%0d", prod_o, cur_lit_prod);
            end
        end
        prev_vo = v_o;
        if (end_chk) begin
            n_chk++;
            if (n_cons != n_expected) begin
                n_fail++;
                $display("FAIL consumed_count got=%0d want=%0d", n_cons, n_expected);
            end
            n_chk++;
            if (n_acc != n_issued) begin
                n_fail++;
                $display("FAIL accepted_count got=%0d want=%0d", n_acc, n_issued);
            end
            n_chk++;
            if (to_cnt != 0) begin
                n_fail++;
                $display("FAIL timeouts got=%0d want=0", to_cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (pending && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) to_cnt++;
    endtask

    task automatic issue(input int a, input int b, input int lp, input int ll, input bit yearly);
        wait_idle();
        a_i      = a[W-1:0];
        b_i      = b[W-1:0];
        lit_prod = lp;
        lit_lat  = ll;
        v_i      = 1'b1;
        yumi_i   = yearly;
        step();
        v_i = 1'b0;
        n_issued++;
    endtask

    task automatic run_op(input int a, input int b, input int lp, input int ll,
                          input int gap, input int ydly, input bit poke);
        int guard;
        for (int i = 0; i < gap; i++) step();
        issue(a, b, lp, ll, (ydly == 0));
        guard = 0;
        while (!model_vo() && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) to_cnt++;
        for (int i = 0; i < ydly; i++) begin
            if (poke) begin
                v_i = i[0];
                a_i = 5'd3;
                b_i = 5'd3;
            end
            step();
        end
        v_i    = 1'b0;
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        n_expected++;
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b1;
        step();

        // directed vectors: a, b, literal product, literal latency
        run_op(31, 31, 961, W,    0, 0, 1'b0);
        run_op( 5,  3,  15, W,    1, 0, 1'b0);
        run_op(31,  1,  31, W,    0, 1, 1'b0);
        run_op(16, 16, 256, W,    2, 0, 1'b0);
        run_op( 0, 17,   0, ZLAT, 0, 0, 1'b0);
        // backpressure with ignored v_i pulses
        run_op( 7,  9,  63, W,    1, 10, 1'b1);

        // reset in the third BUSY cycle discards the operation
        issue(29, 27, -1, -1, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        run_op(6, 6, 36, W, 0, 0, 1'b0);

        // random pairs with random gaps and consumer stalls
        for (int k = 0; k < 1000; k++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 31));
            rb = int'($urandom_range(0, 31));
            run_op(ra, rb, -1, -1, int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        step();
        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
